// File: rtl/conv_fprop2_pkg.sv
// Shared types and defaults for the conv_fprop2 accumulator slice.
package conv_fprop2_pkg;
    localparam int DATA_W   = 32;
    localparam int KLEN_DEF = 25;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic [15:0]               cnt_t;
endpackage

// File: rtl/conv_fprop2_acc_outbuf.sv
// One-entry valid/ready output register: load has priority over drain.
module conv_fprop2_acc_outbuf
    import conv_fprop2_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (ce) begin
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/conv_fprop2_acc.sv
// Window accumulator: sums KLEN products plus a per-window bias and emits one
// result per window. Define CONV_FPROP2_ACC_RELU_EN to clamp negative results to 0.
module conv_fprop2_acc
    import conv_fprop2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int KLEN       = KLEN_DEF,
    parameter int CNT_WIDTH  = $bits(cnt_t)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  win_count,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(KLEN - 1);

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] res;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  last;
    logic                  acc_fire;
    logic                  done;

    assign last     = (cnt == LAST);
    // The final product only waits when the output slot is full and not draining.
    assign in_ready = ce && (!last || !out_valid || out_ready);
    assign acc_fire = in_valid && in_ready;
    assign done     = acc_fire && last;
    assign sum      = ((cnt == '0) ? bias : acc) + din;
    assign busy     = (cnt != '0);

`ifdef CONV_FPROP2_ACC_RELU_EN
    assign res = sum[DATA_WIDTH-1] ? '0 : sum;
`else
    assign res = sum;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            cnt       <= '0;
            win_count <= '0;
        end else if (acc_fire) begin
            if (last) begin
                cnt       <= '0;
                win_count <= win_count + CNT_WIDTH'(1);
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    conv_fprop2_acc_outbuf #(
        .WIDTH (DATA_WIDTH)
    ) u_outbuf (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .load      (done),
        .load_data (res),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data)
    );

endmodule

// File: tb/tb_conv_fprop2_acc.sv
// Bench for conv_fprop2_acc: three instances (KLEN=4,2,1) against a window-list model.
module tb_conv_fprop2_acc;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        out_ready;
    logic [31:0] din;
    logic [31:0] bias;
    logic [2:0]  in_valid;
    logic [2:0]  ird;
    logic [2:0]  ov;
    logic [2:0]  bz;
    logic [31:0] od [3];
    logic [15:0] wc [3];

    int passed = 0;
    int total  = 0;

    int          klen [3] = '{4, 2, 1};
    logic [31:0] wq [3][$];
    logic [31:0] m_bias [3];
    logic [31:0] m_od [3];
    logic        m_ov [3];
    logic [15:0] m_win [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        conv_fprop2_acc #(
            .DATA_WIDTH (32),
            .KLEN       ((g == 0) ? 4 : (g == 1) ? 2 : 1),
            .CNT_WIDTH  (16)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .ce        (ce),
            .in_valid  (in_valid[g]),
            .in_ready  (ird[g]),
            .din       (din),
            .bias      (bias),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_data  (od[g]),
            .win_count (wc[g]),
            .busy      (bz[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] post(input logic [31:0] s);
`ifdef CONV_FPROP2_ACC_RELU_EN
        return s[31] ? 32'd0 : s;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_state();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(m_ov[k]));
            chk($sformatf("out_data%0d", k), od[k], m_od[k]);
            chk($sformatf("win_count%0d", k), 32'(wc[k]), 32'(m_win[k]));
            chk($sformatf("busy%0d", k), 32'(bz[k]), 32'(wq[k].size() != 0));
        end
    endtask

    // Entered and left at posedge+1.
    task automatic step(input int sel, input bit v, input bit c, input bit r,
                        input logic [31:0] d, input logic [31:0] b);
        bit          acc [3];
        bit          exp_r;
        bit          done;
        logic [31:0] s;
        ce        = c;
        out_ready = r;
        din       = d;
        bias      = b;
        in_valid  = v ? 3'(1 << sel) : 3'b000;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_r = c && (wq[k].size() != klen[k] - 1 || !m_ov[k] || r);
            chk($sformatf("in_ready%0d", k), 32'(ird[k]), 32'(exp_r));
            acc[k] = in_valid[k] && exp_r;
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            done = 1'b0;
            if (acc[k]) begin
                if (wq[k].size() == 0) m_bias[k] = b;
                wq[k].push_back(d);
                if (wq[k].size() == klen[k]) begin
                    s = m_bias[k];
                    foreach (wq[k][i]) s = s + wq[k][i];
                    m_od[k]  = post(s);
                    m_ov[k]  = 1'b1;
                    m_win[k] = m_win[k] + 16'd1;
                    wq[k].delete();
                    done = 1'b1;
                end
            end
            if (!done && c && m_ov[k] && r) m_ov[k] = 1'b0;
        end
        #1;
        chk_state();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            wq[k].delete();
            m_od[k]  = '0;
            m_ov[k]  = 1'b0;
            m_win[k] = '0;
        end
        chk_state();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        ce        = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        bias      = '0;
        in_valid  = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset mid-window, then a fresh window from bias.
        step(0, 1, 1, 1, 32'd1, 32'd10);
        step(0, 1, 1, 1, 32'd2, 32'd99);
        chk("busy_mid", 32'(bz[0]), 32'd1);
        do_reset();
        step(0, 1, 1, 1, 32'd1, 32'd10);
        step(0, 1, 1, 1, 32'd2, 32'd0);
        step(0, 1, 1, 1, 32'd3, 32'd0);
        step(0, 1, 1, 1, 32'd4, 32'd0);
        chk("basic_sum", od[0], 32'd20);
        chk("basic_win", 32'(wc[0]), 32'd1);

        // Backpressure on the final product.
        step(0, 1, 1, 0, 32'd5, 32'd0);
        step(0, 1, 1, 0, 32'd5, 32'd7);
        step(0, 1, 1, 0, 32'd5, 32'd7);
        step(0, 1, 1, 0, 32'd5, 32'd7);
        chk("bp_hold_rdy", 32'(ird[0]), 32'd0);
        chk("bp_hold_data", od[0], 32'd20);
        step(0, 1, 1, 0, 32'd5, 32'd7);
        step(0, 1, 1, 1, 32'd5, 32'd7);
        chk("bp_second", od[0], 32'd20);
        chk("bp_valid", 32'(ov[0]), 32'd1);
        chk("bp_win", 32'(wc[0]), 32'd2);
        step(0, 0, 1, 1, 32'd0, 32'd0);

        // ce gating between products 2 and 3.
        step(0, 1, 1, 1, 32'd9, 32'd7);
        step(0, 1, 1, 1, 32'd8, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 32'd100, 32'd0);
        step(0, 1, 1, 1, 32'd6, 32'd0);
        step(0, 1, 1, 1, 32'd5, 32'd0);
        chk("ce_sum", od[0], 32'd35);

        // Wrap and sign, KLEN=2.
        step(1, 1, 1, 1, 32'd1, 32'h7FFF_FFFF);
        step(1, 1, 1, 1, 32'd0, 32'd0);
`ifdef CONV_FPROP2_ACC_RELU_EN
        chk("wrap_relu", od[1], 32'd0);
`else
        chk("wrap_raw", od[1], 32'h8000_0000);
`endif

        // KLEN=1 streaming.
        step(2, 1, 1, 1, 32'd3, -32'sd3);
        chk("k1_a", od[2], 32'd0);
        step(2, 1, 1, 1, 32'd4, -32'sd3);
        chk("k1_b", od[2], 32'd1);
        step(2, 1, 1, 1, 32'd5, -32'sd3);
        chk("k1_c", od[2], 32'd2);
        chk("k1_win", 32'(wc[2]), 32'd3);

        // Randomised traffic across all three instances.
        for (int i = 0; i < 600; i++) begin
            step(int'($urandom_range(2, 0)), bit'($urandom_range(3, 0) != 0),
                 bit'($urandom_range(7, 0) != 0), bit'($urandom_range(2, 0) != 0),
                 $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
